// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read channel: req/ready address handshake plus rvalid data return.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word reads and queues returns for IF/ID.
// Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module if_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  if_fetch_unit_if.master   imem,
  output logic [31:0]       inst_out,
  output logic [31:0]       pc_out,
  output logic              valid_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [31:0]   r_q_inst [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;

  // Only IDLE can request, so outstanding is zero there and the credit test reduces to occupancy.
  always_comb begin
    imem.imem_req  = rst && (r_state == S_IDLE) && (r_count < CNT_FULL);
    imem.imem_addr = r_fetch_pc;
  end

  assign w_accept = imem.imem_req & imem.imem_ready;
  assign w_push   = (r_state == S_WAIT) & imem.imem_rvalid & ~redirect;
  assign w_pop    = w_valid & ~stall & ~redirect;

  // A redirect turns any read that would still be in flight after this edge into a drop.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:         if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT, S_DROP: if (imem.imem_rvalid) w_state_nxt = S_IDLE;
      default:        w_state_nxt = S_IDLE;
    endcase
    if (redirect && (w_state_nxt == S_WAIT)) w_state_nxt = S_DROP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_accept) r_req_pc <= r_fetch_pc;
      if (redirect)      r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (redirect) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW + 1)'(1);
          2'b01:   r_count <= r_count - (AW + 1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wptr] <= imem.imem_rdata;
      r_q_pc[r_wptr]   <= r_req_pc;
    end
  end

  always_comb begin
    w_valid   = (r_count != '0);
    valid_out = w_valid;
    inst_out  = w_valid ? r_q_inst[r_rptr] : NOP_INST;
    pc_out    = w_valid ? r_q_pc[r_rptr]   : '0;
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (w_push)             perf_fetched <= perf_fetched + 32'd1;
      if (!w_valid && !stall) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(w_push && (r_count == CNT_FULL)));

endmodule
